// File: rtl/uart_tx_buffer.sv
// Host-write FIFO feeding an 8N1 UART serializer on TxD.
// FIFO status flags and the serial line are all registered.
module uart_tx_buffer #(
   parameter int unsigned BITWIDTH     = 8,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [BITWIDTH-1:0]       dataIn,
   input  logic                      WR,
   output logic                      FULL,
   output logic                      EMPTY,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      OVERFLOW,
   output logic                      BUSY,
   output logic                      TxD
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned IW  = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
   localparam int unsigned BCW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              state_q;
   logic [BITWIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                ovf_q, ovf_d;
   logic                busy_q;
   logic                txd_q;
   logic [BITWIDTH-1:0] shift_q;
   logic [IW-1:0]       bit_q;
   logic [BCW-1:0]      baud_q;

   logic wr_ok;
   logic pop;
   logic baud_last;
   logic bit_last;

   // FULL is the registered flag, so a write is refused even when a pop frees a slot this cycle.
   always_comb begin
      wr_ok     = WR & ~full_q;
      pop       = (state_q == S_IDLE) && (count_q != '0);
      baud_last = (baud_q == BCW'(CLKS_PER_BIT - 1));
      bit_last  = (bit_q == IW'(BITWIDTH - 1));

      count_d = count_q;
      case ({wr_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
      wptr_d  = wr_ok ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop   ? rptr_q + AW'(1) : rptr_q;
      ovf_d   = ovf_q | (WR & full_q);
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst && wr_ok) begin
         mem_q[wptr_q] <= dataIn;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q  <= 1'b1;
               busy_q <= 1'b0;
               baud_q <= '0;
               if (pop) begin
                  shift_q <= mem_q[rptr_q];
                  state_q <= S_START;
                  txd_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= S_DATA;
                  txd_q   <= shift_q[0];
               end else begin
                  baud_q <= baud_q + BCW'(1);
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_last) begin
                     state_q <= S_STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     bit_q <= bit_q + IW'(1);
                     txd_q <= shift_q[bit_q + IW'(1)];
                  end
               end else begin
                  baud_q <= baud_q + BCW'(1);
               end
            end
            S_STOP: begin
               txd_q <= 1'b1;
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  baud_q <= baud_q + BCW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
               baud_q  <= '0;
            end
         endcase
      end
   end

   assign FULL     = full_q;
   assign EMPTY    = empty_q;
   assign count    = count_q;
   assign OVERFLOW = ovf_q;
   assign BUSY     = busy_q;
   assign TxD      = txd_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized and directed bench for uart_tx_buffer against a queue/frame-timer reference model.
module tb_uart_tx_buffer;

   localparam int unsigned BW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CPB   = 4;
   localparam int unsigned FRAME = (BW + 2) * CPB;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [BW-1:0] dataIn;
   logic          WR;
   logic          FULL, EMPTY, OVERFLOW, BUSY, TxD;
   logic [$clog2(DEPTH):0] count;

   uart_tx_buffer #(
      .BITWIDTH    (BW),
      .DEPTH       (DEPTH),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .dataIn  (dataIn),
      .WR      (WR),
      .FULL    (FULL),
      .EMPTY   (EMPTY),
      .count   (count),
      .OVERFLOW(OVERFLOW),
      .BUSY    (BUSY),
      .TxD     (TxD)
   );

   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int rises[$];
   logic prev_busy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Reference: byte queue plus a frame timer counting cycles since the frame began.
   logic [BW-1:0] m_q[$];
   logic          m_act = 1'b0;
   int            m_t   = 0;
   logic [BW-1:0] m_cur = '0;
   logic          m_ovf = 1'b0;
   logic          m_full;

   always @(posedge Clk) begin
      if (!Rst) begin
         m_q.delete();
         m_act = 1'b0;
         m_t   = 0;
         m_ovf = 1'b0;
      end else begin
         m_full = (m_q.size() == DEPTH);
         if (WR && m_full) m_ovf = 1'b1;
         if (!m_act) begin
            if (m_q.size() != 0) begin
               m_cur = m_q.pop_front();
               m_act = 1'b1;
               m_t   = 0;
            end
         end else begin
            m_t++;
            if (m_t == FRAME) m_act = 1'b0;
         end
         if (WR && !m_full) m_q.push_back(dataIn);
      end
   end

   function automatic logic exp_txd();
      int k;
      if (!m_act) return 1'b1;
      k = m_t / CPB;
      if (k == 0) return 1'b0;
      if (k <= BW) return m_cur[k-1];
      return 1'b1;
   endfunction

   task automatic compare_model();
      chk("txd",   {31'b0, TxD},      {31'b0, exp_txd()});
      chk("busy",  {31'b0, BUSY},     {31'b0, m_act});
      chk("count", 32'(count),        32'(m_q.size()));
      chk("empty", {31'b0, EMPTY},    {31'b0, m_q.size() == 0});
      chk("full",  {31'b0, FULL},     {31'b0, m_q.size() == DEPTH});
      chk("ovf",   {31'b0, OVERFLOW}, {31'b0, m_ovf});
   endtask

   task automatic tick(input logic rst_n, input logic wr, input logic [BW-1:0] d);
      Rst    = rst_n;
      WR     = wr;
      dataIn = d;
      @(posedge Clk);
      @(negedge Clk);
      cyc++;
      if (BUSY === 1'b1 && prev_busy !== 1'b1) rises.push_back(cyc);
      prev_busy = BUSY;
      compare_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0);
   endtask

   logic seq[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   int n;
   logic do_wr;
   logic rst_n;
   int mode;

   initial begin
      Rst = 1'b0; WR = 1'b1; dataIn = 8'h5A;
      @(negedge Clk);

      // Reset held with WR asserted
      tick(1'b0, 1'b1, 8'h5A);
      tick(1'b0, 1'b1, 8'h5A);
      chk("rst_txd",   {31'b0, TxD},      32'd1);
      chk("rst_empty", {31'b0, EMPTY},    32'd1);
      chk("rst_full",  {31'b0, FULL},     32'd0);
      chk("rst_count", 32'(count),        32'd0);
      chk("rst_busy",  {31'b0, BUSY},     32'd0);
      chk("rst_ovf",   {31'b0, OVERFLOW}, 32'd0);
      idle(3);

      // Single byte 0xA5
      tick(1'b1, 1'b1, 8'hA5);
      chk("sb_count1", 32'(count), 32'd1);
      tick(1'b1, 1'b0, '0);
      for (int i = 0; i < int'(FRAME); i++) begin
         chk("sb_bit",  {31'b0, TxD},  {31'b0, seq[i / CPB]});
         chk("sb_busy", {31'b0, BUSY}, 32'd1);
         tick(1'b1, 1'b0, '0);
      end
      chk("sb_busy_end",  {31'b0, BUSY},  32'd0);
      chk("sb_empty_end", {31'b0, EMPTY}, 32'd1);
      idle(3);

      // Fill and overflow
      rises.delete();
      for (int i = 1; i <= 6; i++) begin
         tick(1'b1, 1'b1, 8'(i));
         if (i == 2) chk("fill_overlap_count", 32'(count), 32'd1);
         if (i == 5) chk("fill_full", {31'b0, FULL}, 32'd1);
      end
      chk("fill_ovf", {31'b0, OVERFLOW}, 32'd1);
      chk("fill_count_after_drop", 32'(count), 32'd4);
      idle(5 * 41 + 5);
      chk("fill_frames", 32'(rises.size()), 32'd5);
      for (int i = 1; i < rises.size(); i++)
         chk("fill_gap", 32'(rises[i] - rises[i-1]), 32'd41);
      chk("fill_ovf_sticky", {31'b0, OVERFLOW}, 32'd1);
      chk("fill_drained", 32'(count), 32'd0);

      // Wrap-around
      tick(1'b1, 1'b1, 8'h11);
      tick(1'b1, 1'b1, 8'h22);
      tick(1'b1, 1'b1, 8'h33);
      idle(3 * 41 + 5);
      rises.delete();
      tick(1'b1, 1'b1, 8'h44);
      tick(1'b1, 1'b1, 8'h55);
      tick(1'b1, 1'b1, 8'h66);
      idle(3 * 41 + 5);
      chk("wrap_frames", 32'(rises.size()), 32'd3);
      chk("wrap_count",  32'(count), 32'd0);

      // Reset during DATA bit 3 of the first frame
      tick(1'b1, 1'b1, 8'hFF);
      tick(1'b1, 1'b1, 8'h00);
      idle(CPB + 3 * CPB + 1);
      tick(1'b0, 1'b0, '0);
      chk("mid_rst_txd",   {31'b0, TxD}, 32'd1);
      chk("mid_rst_count", 32'(count),   32'd0);
      rises.delete();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b1, 1'b0, '0);
         if (TxD !== 1'b1) n++;
      end
      chk("mid_rst_quiet_txd",    32'(n), 32'd0);
      chk("mid_rst_quiet_frames", 32'(rises.size()), 32'd0);

      // Write coinciding with the pop edge
      tick(1'b1, 1'b1, 8'h3C);
      tick(1'b1, 1'b1, 8'hC3);
      chk("sim_count", 32'(count), 32'd1);
      idle(2 * 41 + 5);
      chk("sim_drained", 32'(count), 32'd0);

      // Randomized traffic with varying write density and rare resets
      for (int blk = 0; blk < 12; blk++) begin
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 250; i++) begin
            case (mode)
               0:       do_wr = ($urandom_range(0, 59) == 0);
               1:       do_wr = ($urandom_range(0, 29) == 0);
               2:       do_wr = ($urandom_range(0, 3) == 0);
               default: do_wr = ($urandom_range(0, 1) == 0);
            endcase
            rst_n = ($urandom_range(0, 799) != 0);
            tick(rst_n, do_wr, 8'($urandom));
         end
      end
      idle(DEPTH * 41 + 10);
      chk("rand_drained", 32'(count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
